// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
// Imported by fifo_wr_arbiter and rr_picker.
package fifo_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int STALL_W = 16;

endpackage

// File: rtl/rr_picker.sv
// Rotate-priority picker: first valid index at or after i_start.
// Returns i_start itself when nothing is valid.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_start,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [N-1:0] w_rot;
  logic [IW:0]  w_sum;

  assign w_rot = N'({i_valid, i_valid} >> i_start);

  always_comb begin
    o_idx = i_start;
    o_any = 1'b0;
    w_sum = '0;
    for (int k = 0; k < N; k++) begin
      if (!o_any && w_rot[k]) begin
        o_any = 1'b1;
        w_sum = {1'b0, i_start} + (IW+1)'(k);
        if (w_sum >= (IW+1)'(N))
          w_sum = w_sum - (IW+1)'(N);
        o_idx = w_sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a shared FIFO write port.
// Define FIFO_ARB_BURST_EN to hold a grant for up to MAX_BURST beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       fifo_push,
  output logic [WIDTH-1:0]           fifo_din,
  input  logic                       fifo_full,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic [STALL_W-1:0]         stall_cnt
);

  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16 || MAX_BURST < 1) begin : g_bad_cfg
    $error("fifo_wr_arbiter: parameter out of range");
  end

  logic [IW-1:0]      r_rr_ptr;
  logic [STALL_W-1:0] r_stall;
  logic [IW-1:0]      w_start;
  logic [IW-1:0]      w_pick;
  logic [IW-1:0]      w_sel;
  logic               w_any;
  logic               w_accept;
  logic               w_block;

  assign w_start = (r_rr_ptr == IW'(N_REQ-1)) ?
                   '0 : r_rr_ptr + 1'b1;

  rr_picker #(
    .N (N_REQ)
  ) u_pick (
    .i_valid (req_valid),
    .i_start (w_start),
    .o_idx   (w_pick),
    .o_any   (w_any)
  );

  assign w_accept  = w_any & ~fifo_full & rst_n;
  assign w_block   = w_any & fifo_full;
  assign fifo_push = w_accept;
  assign fifo_din  = req_data[int'(w_sel)*WIDTH +: WIDTH];
  assign grant_id  = w_sel;
  assign stall_cnt = r_stall;

  always_comb begin
    req_ready        = '0;
    req_ready[w_sel] = w_accept;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= IW'(N_REQ-1);
      r_stall  <= '0;
    end else begin
      if (w_accept)
        r_rr_ptr <= w_sel;
      if (w_block && r_stall != '1)
        r_stall <= r_stall + 1'b1;
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int BW = $clog2(MAX_BURST+1);

  arb_state_e    r_state;
  arb_state_e    w_state_nx;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] w_owner_nx;
  logic [BW-1:0] r_beats;
  logic [BW-1:0] w_beats_nx;
  logic [BW-1:0] w_beats_inc;
  logic          w_hold;

  assign w_hold      = (r_state == BURST) &&
                       req_valid[r_owner];
  assign w_beats_inc = r_beats + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ARB;
      r_owner <= '0;
      r_beats <= '0;
    end else begin
      r_state <= w_state_nx;
      r_owner <= w_owner_nx;
      r_beats <= w_beats_nx;
    end
  end

  // An owner that drops valid forfeits the lock that cycle.
  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_beats_nx = r_beats;
    if (w_hold) begin
      if (w_accept) begin
        w_beats_nx = w_beats_inc;
        if (w_beats_inc == BW'(MAX_BURST))
          w_state_nx = ARB;
      end
    end else if (w_accept) begin
      if (MAX_BURST > 1) begin
        w_state_nx = BURST;
        w_owner_nx = w_pick;
        w_beats_nx = BW'(1);
      end else begin
        w_state_nx = ARB;
      end
    end else begin
      w_state_nx = ARB;
    end
  end

  always_comb begin
    w_sel = w_hold ? r_owner : w_pick;
  end
`else
  assign w_sel = w_pick;
`endif

endmodule
